// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter that shares one APB master port between two
// command requesters and sequences the SETUP/ACCESS phases toward two slaves.
// PADDR[address_size] selects the slave: 1 -> PSEL1, 0 -> PSEL2.
// Optional feature macro: APB_TIMEOUT_EN (aborts an ACCESS phase after TIMEOUT cycles
// without PREADY and reports it through reqN_err).
module apb_req_arbiter #(
    parameter int data_size    = 7,
    parameter int address_size = 8,
    parameter int TIMEOUT      = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET_n,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [address_size:0] req0_addr,
    input  logic [data_size:0]    req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_done,
    output logic [data_size:0]    req0_rdata,
    output logic                  req0_err,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [address_size:0] req1_addr,
    input  logic [data_size:0]    req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_done,
    output logic [data_size:0]    req1_rdata,
    output logic                  req1_err,
    output logic [address_size:0] PADDR,
    output logic [data_size:0]    PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL1,
    output logic                  PSEL2,
    output logic                  PENABLE,
    input  logic                  PREADY,
    input  logic [data_size:0]    PRDATA
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  lastGrant_q, lastGrant_d;
    logic                  owner_q, owner_d;
    logic [address_size:0] paddr_q, paddr_d;
    logic [data_size:0]    pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel1_q, psel1_d;
    logic                  psel2_q, psel2_d;
    logic                  penable_q, penable_d;
    logic                  done0_q, done0_d;
    logic                  done1_q, done1_d;
    logic [data_size:0]    rdata0_q, rdata0_d;
    logic [data_size:0]    rdata1_q, rdata1_d;

    logic timeoutHit;
    logic accessDone;
    logic slot;
    logic grant0;
    logic grant1;

    // An arbitration slot opens whenever the bus is idle or the current transfer ends.
    // lastGrant_q = 1 means req1 was served last, so req0 wins a tie.
    assign accessDone = (state_q == ACCESS) && (PREADY || timeoutHit);
    assign slot       = (state_q == IDLE) || accessDone;
    assign grant0     = slot && req0_valid && (!req1_valid || lastGrant_q);
    assign grant1     = slot && req1_valid && (!req0_valid || !lastGrant_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign PWRITE     = pwrite_q;
    assign PSEL1      = psel1_q;
    assign PSEL2      = psel2_q;
    assign PENABLE    = penable_q;
    assign req0_done  = done0_q;
    assign req1_done  = done1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;

`ifdef APB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic            err0_q;
    logic            err1_q;

    assign timeoutHit = (state_q == ACCESS) && !PREADY && (cnt_q == CntW'(TIMEOUT - 1));
    assign req0_err   = err0_q;
    assign req1_err   = err1_q;

    // Count ACCESS cycles of the current transfer; any other state restarts the count.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // Record whether the completing transfer was a timeout abort, for its owner only.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else if (accessDone) begin
            if (owner_q) begin
                err1_q <= timeoutHit;
            end else begin
                err0_q <= timeoutHit;
            end
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign req0_err   = 1'b0;
    assign req1_err   = 1'b0;
`endif

    // Next-state logic: phase sequencing, completion reporting and command latching on grant.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        owner_d     = owner_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel1_d     = psel1_q;
        psel2_d     = psel2_q;
        penable_d   = penable_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            IDLE: begin
                psel1_d   = 1'b0;
                psel2_d   = 1'b0;
                penable_d = 1'b0;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (accessDone) begin
                    state_d   = IDLE;
                    psel1_d   = 1'b0;
                    psel2_d   = 1'b0;
                    penable_d = 1'b0;
                    if (owner_q) begin
                        done1_d = 1'b1;
                        if (timeoutHit) begin
                            rdata1_d = '0;
                        end else if (!pwrite_q) begin
                            rdata1_d = PRDATA;
                        end
                    end else begin
                        done0_d = 1'b1;
                        if (timeoutHit) begin
                            rdata0_d = '0;
                        end else if (!pwrite_q) begin
                            rdata0_d = PRDATA;
                        end
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                psel1_d   = 1'b0;
                psel2_d   = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        if (grant0 || grant1) begin
            state_d     = SETUP;
            owner_d     = grant1;
            lastGrant_d = grant1;
            penable_d   = 1'b0;
            if (grant1) begin
                paddr_d  = req1_addr;
                pwdata_d = req1_wdata;
                pwrite_d = req1_write;
                psel1_d  = req1_addr[address_size];
                psel2_d  = !req1_addr[address_size];
            end else begin
                paddr_d  = req0_addr;
                pwdata_d = req0_wdata;
                pwrite_d = req0_write;
                psel1_d  = req0_addr[address_size];
                psel2_d  = !req0_addr[address_size];
            end
        end
    end

    // State register; reset aborts any transfer and gives req0 the first grant.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            owner_q     <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel1_q     <= psel1_d;
            psel2_q     <= psel2_d;
            penable_q   <= penable_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: scoreboard bench for apb_req_arbiter. Stimulus pushes the
// hand-computed SETUP-phase bus contents and completion results into queues; a monitor
// pops and compares whenever the DUT shows a SETUP phase or a done pulse.
// Build with APB_TIMEOUT_EN defined to also exercise the ACCESS timeout.
module tb_apb_req_arbiter;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] wdata;
        logic       wr;
        logic       psel1;
    } setupT;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         expCyc;
    } doneT;

    logic       PCLK;
    logic       PRESET_n;
    logic       req0_valid, req0_write, req0_ready, req0_done, req0_err;
    logic [8:0] req0_addr;
    logic [7:0] req0_wdata, req0_rdata;
    logic       req1_valid, req1_write, req1_ready, req1_done, req1_err;
    logic [8:0] req1_addr;
    logic [7:0] req1_wdata, req1_rdata;
    logic [8:0] PADDR;
    logic [7:0] PWDATA;
    logic       PWRITE, PSEL1, PSEL2, PENABLE, PREADY;
    logic [7:0] PRDATA;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    waitCfg = 0;
    int    waitCnt = 0;
    logic [7:0] slaveData = 8'h00;

    setupT setupQ[$];
    doneT  done0Q[$];
    doneT  done1Q[$];

    apb_req_arbiter #(.data_size(7), .address_size(8), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET_n(PRESET_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL1(PSEL1), .PSEL2(PSEL2),
        .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    // 10 ns clock
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // cycle counter used for completion latency checks
    always @(posedge PCLK) cyc++;

    // slave model: PREADY rises after waitCfg wait cycles of the ACCESS phase
    always @(negedge PCLK) begin
        if ((PSEL1 || PSEL2) && PENABLE) begin
            waitCnt++;
            PREADY = (waitCnt > waitCfg);
        end else begin
            waitCnt = 0;
            PREADY  = 1'b0;
        end
        PRDATA = slaveData;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushSetup(input logic [8:0] addr, input logic [7:0] wd, input logic wr,
                             input logic psel1);
        setupT s;
        s.addr = addr; s.wdata = wd; s.wr = wr; s.psel1 = psel1;
        setupQ.push_back(s);
    endtask

    // monitor: overlap invariant, SETUP-phase bus contents, completion results
    always @(negedge PCLK) begin
        setupT s;
        doneT  d;
        checkOutput("pselOverlap", {31'd0, PSEL1 && PSEL2}, 32'd0);
        if ((PSEL1 || PSEL2) && !PENABLE) begin
            if (setupQ.size() == 0) begin
                checkOutput("unexpectedSetup", {23'd0, PADDR}, 32'h0000_FFFF);
            end else begin
                s = setupQ.pop_front();
                checkOutput("setupBus", {12'd0, PADDR, PWDATA, PWRITE, PSEL1, PSEL2},
                            {12'd0, s.addr, s.wdata, s.wr, s.psel1, !s.psel1});
            end
        end
        if (req0_done) begin
            if (done0Q.size() == 0) begin
                checkOutput("unexpectedDone0", 32'd1, 32'd0);
            end else begin
                d = done0Q.pop_front();
                checkOutput("done0Result", {23'd0, req0_rdata, req0_err}, {23'd0, d.rdata, d.err});
                if (d.expCyc >= 0) checkOutput("done0Cycle", cyc, d.expCyc);
            end
        end
        if (req1_done) begin
            if (done1Q.size() == 0) begin
                checkOutput("unexpectedDone1", 32'd1, 32'd0);
            end else begin
                d = done1Q.pop_front();
                checkOutput("done1Result", {23'd0, req1_rdata, req1_err}, {23'd0, d.rdata, d.err});
                if (d.expCyc >= 0) checkOutput("done1Cycle", cyc, d.expCyc);
            end
        end
    end

    // drive one command on requester req and hold it until accepted (bounded)
    task automatic applyStimulus(input int req, input logic wr, input logic [8:0] addr,
                                 input logic [7:0] wd, input bit pushDone,
                                 input logic [7:0] expRdata, input logic expErr, input int lat);
        doneT d;
        bit   got;
        @(negedge PCLK);
        d.rdata  = expRdata;
        d.err    = expErr;
        d.expCyc = (lat < 0) ? -1 : cyc + lat;
        if (pushDone) begin
            if (req == 0) done0Q.push_back(d);
            else          done1Q.push_back(d);
        end
        if (req == 0) begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wd;
        end else begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wd;
        end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            if ((req == 0 && req0_ready) || (req == 1 && req1_ready)) got = 1'b1;
            else @(negedge PCLK);
        end
        checks++;
        if (got) begin
            @(posedge PCLK);
        end else begin
            errors++;
            $display("[TB] FAIL grantWait req%0d: ready never seen, required 1 within 200 cycles", req);
        end
        #1;
        if (req == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
    endtask

    // wait (bounded) until every queued expectation has been consumed
    task automatic waitIdle();
        int n;
        n = 0;
        while ((setupQ.size() != 0 || done0Q.size() != 0 || done1Q.size() != 0) && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: expectations still pending after 100 cycles, required 0");
        end
        repeat (2) @(negedge PCLK);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doneT d;
        int   n;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        PREADY = 0; PRDATA = '0;
        PRESET_n = 1'b1;
        #1 PRESET_n = 1'b0;
        repeat (3) @(negedge PCLK);
        #1;
        checkOutput("resetBus", {12'd0, PADDR, PWDATA, PWRITE, PSEL1, PSEL2}, 32'd0);
        checkOutput("resetReq", {12'd0, PENABLE, req0_done, req1_done, req0_err, req1_err,
                                 req0_rdata, req1_rdata}, 32'd0);
        @(negedge PCLK);
        PRESET_n = 1'b1;

        // 1: req0 write to slave 1, zero-wait slave, done three cycles after issue
        $display("[TB] test 1: single write, zero wait");
        waitCfg = 0;
        pushSetup(9'h105, 8'hA5, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 9'h105, 8'hA5, 1'b1, 8'h00, 1'b0, 3);
        waitIdle();

        // 2: req1 read from slave 2 with three wait states
        $display("[TB] test 2: read with wait states");
        waitCfg = 3; slaveData = 8'h3C;
        pushSetup(9'h010, 8'h00, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 9'h010, 8'h00, 1'b1, 8'h3C, 1'b0, 6);
        waitIdle();

        // 3: both requesters always pending -> alternating grants 0,1,0,1
        $display("[TB] test 3: round-robin back-to-back");
        waitCfg = 0; slaveData = 8'h77;
        pushSetup(9'h1A0, 8'h11, 1'b1, 1'b1);
        pushSetup(9'h130, 8'h00, 1'b0, 1'b1);
        pushSetup(9'h022, 8'h22, 1'b1, 1'b0);
        pushSetup(9'h040, 8'h00, 1'b0, 1'b0);
        fork
            begin
                applyStimulus(0, 1'b1, 9'h1A0, 8'h11, 1'b1, 8'h00, 1'b0, -1);
                applyStimulus(0, 1'b1, 9'h022, 8'h22, 1'b1, 8'h00, 1'b0, -1);
            end
            begin
                applyStimulus(1, 1'b0, 9'h130, 8'h00, 1'b1, 8'h77, 1'b0, -1);
                applyStimulus(1, 1'b0, 9'h040, 8'h00, 1'b1, 8'h77, 1'b0, -1);
            end
        join
        waitIdle();

        // 4: reset during ACCESS aborts with no done; afterwards req0 wins a tie
        $display("[TB] test 4: reset mid-transfer");
        waitCfg = 10;
        pushSetup(9'h155, 8'h5A, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 9'h155, 8'h5A, 1'b0, 8'h00, 1'b0, -1);
        n = 0;
        while (!PENABLE && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        checkOutput("t4AccessReached", {31'd0, PENABLE}, 32'd1);
        @(negedge PCLK);
        #2 PRESET_n = 1'b0;
        #1;
        checkOutput("t4ResetBus", {12'd0, PADDR, PWDATA, PWRITE, PSEL1, PSEL2}, 32'd0);
        checkOutput("t4ResetReq", {12'd0, PENABLE, req0_done, req1_done, req0_err, req1_err,
                                   req0_rdata, req1_rdata}, 32'd0);
        repeat (2) @(negedge PCLK);
        PRESET_n = 1'b1;
        waitCfg = 0; slaveData = 8'hC3;
        pushSetup(9'h0F0, 8'h00, 1'b0, 1'b0);
        pushSetup(9'h111, 8'h00, 1'b0, 1'b1);
        fork
            applyStimulus(0, 1'b0, 9'h0F0, 8'h00, 1'b1, 8'hC3, 1'b0, 3);
            applyStimulus(1, 1'b0, 9'h111, 8'h00, 1'b1, 8'hC3, 1'b0, -1);
        join
        waitIdle();

        // 6: req1 withdraws while req0 holds the grant -> only req0 transfers
        $display("[TB] test 6: withdrawn request");
        pushSetup(9'h000, 8'h44, 1'b1, 1'b0);
        @(negedge PCLK);
        d.rdata = 8'hC3; d.err = 1'b0; d.expCyc = cyc + 3;
        done0Q.push_back(d);
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 9'h000; req0_wdata = 8'h44;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h1FF; req1_wdata = 8'h00;
        #1;
        checkOutput("t6Ready0", {31'd0, req0_ready}, 32'd1);
        checkOutput("t6Ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge PCLK);
        #1 req0_valid = 1'b0;
        @(negedge PCLK);
        req1_valid = 1'b0;
        waitIdle();
        repeat (5) @(negedge PCLK);

`ifdef APB_TIMEOUT_EN
        // 5: slave never ready -> abort after 16 ACCESS cycles with err and zero rdata
        $display("[TB] test 5: ACCESS timeout");
        waitCfg = 1000; slaveData = 8'hEE;
        pushSetup(9'h020, 8'h00, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 9'h020, 8'h00, 1'b1, 8'h00, 1'b1, 18);
        waitIdle();
`endif

        checkOutput("setupQEmpty", setupQ.size(), 32'd0);
        checkOutput("done0QEmpty", done0Q.size(), 32'd0);
        checkOutput("done1QEmpty", done1Q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
